// File: rtl/sum_arb_pkg.sv
// sum_arb_pkg: shared types and helpers for the sum_arbiter block.
package sum_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Modular increment of a requester index, wrapping at nreq (any nreq >= 1).
  function automatic int unsigned next_ptr(input int unsigned id, input int unsigned nreq);
    return (id + 32'd1 >= nreq) ? 32'd0 : id + 32'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; the first requester at or after ptr wins.
module rr_arbiter #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt_c,
  output logic [IDW-1:0]  gnt_id_c,
  output logic            any_c
);

  // Walk outward from ptr, wrapping without a modulo so non-power-of-two NREQ works.
  always_comb begin
    int unsigned idx;
    gnt_c    = '0;
    gnt_id_c = '0;
    any_c    = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!any_c && req[IDW'(idx)]) begin
        any_c             = 1'b1;
        gnt_c[IDW'(idx)]  = 1'b1;
        gnt_id_c          = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/sum_arbiter.sv
// sum_arbiter: round-robin shares one registered adder among NREQ requesters.
// Optional macro SUM_ARB_SAT_EN: saturate on carry and expose resp_sat.
module sum_arbiter
  import sum_arb_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned NREQ  = 4,
  localparam int unsigned IDW   = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req_valid,
  output logic [NREQ-1:0]  req_ready,
  input  logic [WIDTH-1:0] req_a [NREQ],
  input  logic [WIDTH-1:0] req_b [NREQ],
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [IDW-1:0]   resp_id,
  output logic [WIDTH:0]   resp_sum
`ifdef SUM_ARB_SAT_EN
  ,
  output logic             resp_sat
`endif
);

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [IDW-1:0]   gnt_id_q, gnt_id_d;
  logic [WIDTH:0]   sum_q, sum_d;
  logic             resp_valid_q, resp_valid_d;
  logic [WIDTH:0]   raw_sum_c;
  logic [NREQ-1:0]  arb_gnt_c;
  logic [IDW-1:0]   arb_id_c;
  logic             arb_any_c;
`ifdef SUM_ARB_SAT_EN
  logic             sat_q, sat_d;
`endif

  rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
    .req      (req_valid),
    .ptr      (rr_ptr_q),
    .gnt_c    (arb_gnt_c),
    .gnt_id_c (arb_id_c),
    .any_c    (arb_any_c)
  );

  // State and datapath registers; synchronous reset drops any in-flight transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      gnt_id_q     <= '0;
      sum_q        <= '0;
      resp_valid_q <= 1'b0;
`ifdef SUM_ARB_SAT_EN
      sat_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      gnt_id_q     <= gnt_id_d;
      sum_q        <= sum_d;
      resp_valid_q <= resp_valid_d;
`ifdef SUM_ARB_SAT_EN
      sat_q        <= sat_d;
`endif
    end
  end

  // Next-state: grant -> add -> hold until the consumer takes the result.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arb_any_c) state_d = ADD;
      ADD:     state_d = HOLD;
      HOLD:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant is only offered in IDLE and never while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && !rst) req_ready = arb_gnt_c;
  end

  // Operand capture, adder stage and pointer update; pointer moves only on accept.
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    gnt_id_d     = gnt_id_q;
    sum_d        = sum_q;
    resp_valid_d = resp_valid_q;
    raw_sum_c    = {1'b0, op_a_q} + {1'b0, op_b_q};
`ifdef SUM_ARB_SAT_EN
    sat_d        = sat_q;
`endif
    case (state_q)
      IDLE: begin
        if (arb_any_c) begin
          op_a_d   = req_a[arb_id_c];
          op_b_d   = req_b[arb_id_c];
          gnt_id_d = arb_id_c;
        end
      end
      ADD: begin
        resp_valid_d = 1'b1;
`ifdef SUM_ARB_SAT_EN
        sat_d = raw_sum_c[WIDTH];
        sum_d = raw_sum_c[WIDTH] ? {1'b0, {WIDTH{1'b1}}} : raw_sum_c;
`else
        sum_d = raw_sum_c;
`endif
      end
      HOLD: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          rr_ptr_d     = IDW'(next_ptr(32'(gnt_id_q), NREQ));
        end
      end
      default: ;
    endcase
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = gnt_id_q;
  assign resp_sum   = sum_q;
`ifdef SUM_ARB_SAT_EN
  assign resp_sat   = sat_q;
`endif

endmodule

// File: tb/tb_sum_arbiter.sv
// tb_sum_arbiter: directed scoreboard bench for sum_arbiter (NREQ=4 and NREQ=3 instances).
module tb_sum_arbiter;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [3:0]   rv, rrdy;
  logic [W-1:0] ra [4];
  logic [W-1:0] rb [4];
  logic         pv, pr;
  logic [1:0]   pid;
  logic [W:0]   psum;

  logic [2:0]   v3, rdy3;
  logic [W-1:0] a3 [3];
  logic [W-1:0] b3 [3];
  logic         pv3, pr3;
  logic [1:0]   pid3;
  logic [W:0]   psum3;

`ifdef SUM_ARB_SAT_EN
  logic         psat, psat3;
`endif

  sum_arbiter #(.WIDTH(W), .NREQ(4)) dut (
    .clk(clk), .rst(rst), .req_valid(rv), .req_ready(rrdy), .req_a(ra), .req_b(rb),
    .resp_valid(pv), .resp_ready(pr), .resp_id(pid), .resp_sum(psum)
`ifdef SUM_ARB_SAT_EN
    , .resp_sat(psat)
`endif
  );

  sum_arbiter #(.WIDTH(W), .NREQ(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(v3), .req_ready(rdy3), .req_a(a3), .req_b(b3),
    .resp_valid(pv3), .resp_ready(pr3), .resp_id(pid3), .resp_sum(psum3)
`ifdef SUM_ARB_SAT_EN
    , .resp_sat(psat3)
`endif
  );

  typedef struct {
    int         id;
    logic [W:0] sum;
    logic       sat;
  } exp_t;

  exp_t q4[$];
  exp_t q3[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Build an expected response from a hand-computed raw sum.
  function automatic exp_t mk(input int id, input logic [W:0] raw);
    exp_t e;
    e.id = id;
`ifdef SUM_ARB_SAT_EN
    e.sat = raw[W];
    e.sum = raw[W] ? 9'h0FF : raw;
`else
    e.sat = 1'b0;
    e.sum = raw;
`endif
    return e;
  endfunction

  task automatic exp4(input int id, input logic [W:0] raw);
    q4.push_back(mk(id, raw));
  endtask

  task automatic exp3(input int id, input logic [W:0] raw);
    q3.push_back(mk(id, raw));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Response monitor for the NREQ=4 instance.
  always @(negedge clk) begin
    if (!rst && pv && pr) begin
      exp_t e;
      if (q4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp4_unexpected: got id %0d sum %0h expected none", pid, psum);
      end else begin
        e = q4.pop_front();
        check("resp4_id", 32'(pid), 32'(e.id));
        check("resp4_sum", 32'(psum), 32'(e.sum));
`ifdef SUM_ARB_SAT_EN
        check("resp4_sat", 32'(psat), 32'(e.sat));
`endif
      end
    end
  end

  // Response monitor for the NREQ=3 instance.
  always @(negedge clk) begin
    if (!rst && pv3 && pr3) begin
      exp_t e;
      if (q3.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp3_unexpected: got id %0d sum %0h expected none", pid3, psum3);
      end else begin
        e = q3.pop_front();
        check("resp3_id", 32'(pid3), 32'(e.id));
        check("resp3_sum", 32'(psum3), 32'(e.sum));
`ifdef SUM_ARB_SAT_EN
        check("resp3_sat", 32'(psat3), 32'(e.sat));
`endif
      end
    end
  end

  // One isolated transaction with the consumer always ready.
  task automatic single(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic [W:0] raw);
    rv = 4'(1 << id);
    ra[id] = a;
    rb[id] = b;
    pr = 1'b1;
    exp4(id, raw);
    smp();
    check("single_grant", 32'(rrdy), 32'(1 << id));
    tick();
    rv = '0;
    smp();
    check("single_add_valid", 32'(pv), 32'd0);
    tick();
    smp();
    check("single_hold_valid", 32'(pv), 32'd1);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int         ord [6];
    logic [3:0] g;
    ord = '{0, 1, 2, 3, 0, 1};
    rst = 1'b1;
    rv = '0;
    pr = 1'b1;
    v3 = '0;
    pr3 = 1'b1;
    for (int i = 0; i < 4; i++) begin ra[i] = '0; rb[i] = '0; end
    for (int i = 0; i < 3; i++) begin a3[i] = '0; b3[i] = '0; end
    tick();
    tick();
    smp();
    check("rst_valid", 32'(pv), 32'd0);
    check("rst_ready", 32'(rrdy), 32'd0);
    check("rst_id", 32'(pid), 32'd0);
    check("rst_sum", 32'(psum), 32'd0);
    check("rst_valid3", 32'(pv3), 32'd0);
    tick();
    rst = 1'b0;

    // Isolated transactions, including carry and overflow.
    single(2, 8'h10, 8'h05, 9'h015);
    single(3, 8'hFF, 8'h01, 9'h100);
    single(0, 8'hFF, 8'hFF, 9'h1FE);
    single(1, 8'h00, 8'h00, 9'h000);
    single(2, 8'h80, 8'h80, 9'h100);

    // All four continuously valid from ptr=0: one grant every 3 cycles.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ra[0] = 8'h11; rb[0] = 8'h01;
    ra[1] = 8'h22; rb[1] = 8'h02;
    ra[2] = 8'h33; rb[2] = 8'h03;
    ra[3] = 8'hF0; rb[3] = 8'h20;
    exp4(0, 9'h012); exp4(1, 9'h024); exp4(2, 9'h036);
    exp4(3, 9'h110); exp4(0, 9'h012); exp4(1, 9'h024);
    rv = 4'hF;
    for (int c = 0; c < 18; c++) begin
      smp();
      g = (c % 3 == 0) ? 4'(1 << ord[c / 3]) : 4'd0;
      check("rr_grant", 32'(rrdy), 32'(g));
      tick();
    end
    rv = '0;

    // Back-pressure: 5 stalled HOLD cycles, accept on the 6th; ptr is now 2.
    pr = 1'b0;
    rv = 4'b0100; ra[2] = 8'h40; rb[2] = 8'h41;
    exp4(2, 9'h081);
    smp();
    check("bp_grant", 32'(rrdy), 32'h4);
    tick();
    rv = 4'b1011; ra[3] = 8'h05; rb[3] = 8'h06;
    smp();
    check("bp_add_ready", 32'(rrdy), 32'd0);
    tick();
    for (int k = 0; k < 5; k++) begin
      smp();
      check("bp_valid", 32'(pv), 32'd1);
      check("bp_sum", 32'(psum), 32'h081);
      check("bp_id", 32'(pid), 32'd2);
      check("bp_ready", 32'(rrdy), 32'd0);
      tick();
    end
    pr = 1'b1;
    smp();
    check("bp_accept_valid", 32'(pv), 32'd1);
    check("bp_accept_no_grant", 32'(rrdy), 32'd0);
    tick();
    exp4(3, 9'h00B);
    smp();
    check("bp_next_grant", 32'(rrdy), 32'h8);
    tick();
    rv = '0;
    tick();
    smp();
    check("bp_next_valid", 32'(pv), 32'd1);
    tick();

    // Reset in HOLD drops the result; ptr returns to 0 so requester 1 wins over 3.
    pr = 1'b0;
    rv = 4'b0100; ra[2] = 8'h01; rb[2] = 8'h02;
    smp();
    check("rh_grant", 32'(rrdy), 32'h4);
    tick();
    rv = '0;
    tick();
    smp();
    check("rh_hold_valid", 32'(pv), 32'd1);
    tick();
    rst = 1'b1;
    rv = 4'b1010; ra[1] = 8'h21; rb[1] = 8'h12; ra[3] = 8'h77; rb[3] = 8'h01;
    smp();
    check("rh_rst_ready", 32'(rrdy), 32'd0);
    tick();
    rst = 1'b0;
    pr = 1'b1;
    exp4(1, 9'h033);
    smp();
    check("rh_valid_dropped", 32'(pv), 32'd0);
    check("rh_grant_after", 32'(rrdy), 32'h2);
    tick();
    rv = '0;
    tick();
    smp();
    check("rh_next_valid", 32'(pv), 32'd1);
    tick();

    // NREQ=3: pointer wraps from 2 to 0, then advances to 1 so 2 wins next.
    v3 = 3'b100; a3[2] = 8'h0A; b3[2] = 8'h0B;
    exp3(2, 9'h015);
    smp();
    check("n3_grant2", 32'(rdy3), 32'h4);
    tick();
    v3 = '0;
    tick();
    smp();
    check("n3_valid2", 32'(pv3), 32'd1);
    tick();
    v3 = 3'b101; a3[0] = 8'h30; b3[0] = 8'h03; a3[2] = 8'h7F; b3[2] = 8'h81;
    exp3(0, 9'h033);
    exp3(2, 9'h100);
    smp();
    check("n3_wrap_grant0", 32'(rdy3), 32'h1);
    tick();
    smp();
    check("n3_add_ready", 32'(rdy3), 32'd0);
    tick();
    smp();
    tick();
    smp();
    check("n3_grant2_again", 32'(rdy3), 32'h4);
    tick();
    v3 = '0;
    tick();
    smp();
    check("n3_valid_last", 32'(pv3), 32'd1);
    tick();

    tick();
    tick();
    check("q4_drained", 32'(q4.size()), 32'd0);
    check("q3_drained", 32'(q3.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
